prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
Programmable integer clock divider that generates clkdiv and bypass, which feed the glitch-free output clock mux. It divides clkin by N (2..2^DIV_W-1) with 50% duty for both even and odd N. Odd N uses a negedge-retimed phase. Ratio changes are shadowed and applied only at a period boundary, so clkdiv never produces a runt pulse. N of 0 or 1 selects bypass mode.

Parameters:
DIV_W, 8, width of the ratio field; the maximum ratio is 2^DIV_W-1.
RST_RATIO, 2, active and pending ratio after reset; must be < 2^DIV_W.

Ports:
clkin  input  1  source clock; all state is on posedge, except the odd-phase flop on negedge.
rst  input  1  asynchronous, active-high reset.
cfg_wr  input  1  single-cycle write strobe for cfg_ratio, sampled on posedge clkin.
cfg_ratio  input  DIV_W  requested divide ratio N.
cfg_busy  output  1  high while a written ratio is pending and not yet applied.
act_ratio  output  DIV_W  ratio currently in effect.
clkdiv  output  1  divided clock, to the output mux.
bypass  output  1  high when act_ratio < 2, to the output mux select.

Behaviour:
- Reset is asynchronous and active-high; reset is rst, clock is clkin. Reset values:
  - cnt=0, pos_q=0, neg_q=0, clkdiv=0.
  - pend and act_ratio = RST_RATIO; cfg_busy=0; bypass=(RST_RATIO<2).
- Counter cnt (DIV_W bits):
  - When act_ratio>=2: cnt increments on each posedge and wraps to 0 when cnt==act_ratio-1.
  - In bypass: cnt is held at 0.
- Boundary:
  - Divide mode: the posedge where cnt==act_ratio-1.
  - Bypass: every posedge.
- Phase generation: pos_q <= (cnt_next < act_ratio>>1) at each posedge, and is forced to 0 in bypass.
- Odd phase: neg_q <= pos_q on each negedge clkin; async reset to 0.
- Output select: clkdiv = act_ratio[0] ? (pos_q | neg_q) : pos_q.
  - Even N: high for N/2 clkin cycles.
  - Odd N: high for N/2 cycles (real division, e.g. 1.5 cycles for N=3).
  - Period is always N clkin cycles.
- Glitch-free boundary: at every boundary, pos_q and neg_q are both already low, so switching act_ratio (including the parity change of the odd/even select) cannot glitch clkdiv.
- Config write:
  - cfg_wr=1 → pend<=cfg_ratio and cfg_busy<=1 on the same posedge.
  - A write while busy overwrites pend; the last write wins.
- Apply:
  - At a boundary with cfg_busy=1 → act_ratio<=pend, cfg_busy<=0, cnt<=0.
  - A cfg_wr coinciding with a boundary takes priority for cfg_busy and pend: the old pend is applied, the new pend stays pending (busy=1).
- Bypass entry: on apply of N<2, bypass goes high on that posedge. clkdiv is already low and stays low; the counter freezes.
- Bypass exit: on apply of N>=2, the write is applied on the next posedge. bypass drops, cnt=0, and the first clkdiv high phase starts on the following posedge.
- Zero latency requirement: bypass and act_ratio change on the same posedge; both are registered, with no combinational path from cfg_*.
- Mid-operation reset: all outputs return immediately to their reset values; the pending write is lost.
- Equal-ratio write: writing the same ratio still sets busy and applies at the boundary, and the period is undisturbed.

Decomposition:
- Package clkdiv_pkg holds:
  - DIV_W default constant;
  - typedef ratio_t (logic [DIV_W-1:0]);
  - function is_bypass(ratio_t), returning N<2.
  - The output mux shares it.
- Sub-module clkdiv_phase_gen: cnt, pos_q, neg_q and the clkdiv select. Inputs are act_ratio and bypass; it outputs clkdiv and the boundary pulse.
- The top level holds the shadow register, the busy flag and the apply logic.

Test Plan:
- Reset check: RST_RATIO=2, assert rst mid-cycle → clkdiv=0, bypass=0, cfg_busy=0, act_ratio=2 immediately. After release, clkdiv toggles every clkin cycle (period 2).
- Even ratio: write N=4 → cfg_busy=1 until the boundary, then act_ratio=4. clkdiv period is 4 clkin cycles, high exactly 2 cycles, high/low ratio 50%.
- Odd ratio: write N=3, then N=7 → clkdiv high 1.5 and 3.5 clkin periods, periods 3 and 7. Check for no glitch at the 3→7 changeover (min pulse width >= 1.5 cycles).
- Mid-period update: N=6 running, write 5 at cnt=2 → the current 6-cycle period completes and the next period is 5. Write 9 then 10 while busy → only 10 is applied.
- Bypass: write 1 → bypass=1 at the boundary, clkdiv stays low. Write 0 → still bypass. Write 4 → bypass=0 one posedge later, and the first rising clkdiv arrives on the following posedge.
- Write at boundary: cfg_wr=1 exactly on the cnt==N-1 cycle with a prior pend → the prior pend is applied, cfg_busy stays 1, and the new value is applied at the next boundary.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider and the output clock mux.
package clkdiv_pkg;

  // Default width of the ratio field; the largest ratio is 2**DefaultDivW - 1.
  localparam int unsigned DefaultDivW = 8;

  typedef logic [DefaultDivW-1:0] ratio_t;

  // Ratios 0 and 1 cannot be divided; the output mux passes clkin straight through instead.
  function automatic logic is_bypass(input ratio_t n);
    return n < ratio_t'(2);
  endfunction

endpackage

// File: rtl/clkdiv_phase_gen.sv
// Counter and phase flops for the divider. Even ratios use the posedge phase alone. Odd ratios
// OR in a copy of it retimed by half a clkin cycle, which stretches the high time to N/2 cycles.
module clkdiv_phase_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [DIV_W-1:0] act_ratio_i,    // ratio in effect this cycle
  input  logic             bypass_i,       // bypass in effect this cycle
  input  logic             bypass_next_i,  // bypass state taking effect at this posedge
  output logic             boundary_o,     // this posedge ends a period
  output logic             clkdiv_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             was_byp_q;
  logic             wrap;

  assign half = act_ratio_i >> 1;
  assign wrap = (cnt_q == act_ratio_i - DIV_W'(1));

  // The first posedge after leaving bypass is also a boundary. It starts a full period, so the
  // first high phase after bypass exit is never shortened.
  assign boundary_o = bypass_i | was_byp_q | wrap;

  // Next count and next posedge phase; a new period always opens with the phase high, unless
  // bypass is in force now or is taking effect at this edge.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    pos_d = 1'b0;
    if (boundary_o) begin
      cnt_d = '0;
      pos_d = ~bypass_i & ~bypass_next_i;
    end else begin
      pos_d = (cnt_d < half);
    end
  end

  // Posedge state: counter, main phase and the one-cycle bypass history.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pos_q     <= 1'b0;
      was_byp_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      was_byp_q <= bypass_i;
    end
  end

  // Half-cycle retimed copy of the main phase, used only for odd ratios.
  always_ff @(negedge clkin or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Both phases are low at every boundary. The parity select can therefore change with
  // act_ratio without a glitch.
  assign clkdiv_o = act_ratio_i[0] ? (pos_q | neg_q) : pos_q;

  // Safety net for the glitch-free changeover argument above.
  always_ff @(posedge clkin) begin
    if (!rst) begin
      assert (!boundary_o || (!pos_q && !neg_q))
        else $error("clkdiv_phase_gen: phase high at a period boundary");
      assert (bypass_i || (cnt_q < act_ratio_i))
        else $error("clkdiv_phase_gen: counter outside the active ratio");
    end
  end

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable integer clock divider. A written ratio is held in a shadow register and is
// applied only at a period boundary, so clkdiv never produces a runt pulse.
module prog_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W     = DefaultDivW,
  parameter int unsigned RST_RATIO = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_ratio,
  output logic             cfg_busy,
  output logic [DIV_W-1:0] act_ratio,
  output logic             clkdiv,
  output logic             bypass
);

  localparam logic [DIV_W-1:0] RstRatio  = DIV_W'(RST_RATIO);
  localparam logic             RstBypass = (RST_RATIO < 2);

  logic [DIV_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic             busy_q, busy_d;
  logic             byp_q, byp_d;
  logic             boundary;
  logic             apply;
  logic             pend_byp;

  // The package helper covers ratios up to its own width; wider builds compare directly.
  if (DIV_W <= DefaultDivW) begin : g_pkg_byp
    assign pend_byp = is_bypass(ratio_t'(pend_q));
  end else begin : g_wide_byp
    assign pend_byp = (pend_q < DIV_W'(2));
  end

  assign apply = boundary & busy_q;

  // Shadow/apply next state. A write on the same edge as an apply wins the shadow register and
  // the busy flag, so the older pending value is applied and the new one stays pending.
  always_comb begin
    pend_d = cfg_wr ? cfg_ratio : pend_q;
    busy_d = cfg_wr | (busy_q & ~boundary);
    act_d  = apply ? pend_q : act_q;
    byp_d  = apply ? pend_byp : byp_q;
  end

  // Configuration registers. Outputs come straight from these flops, so nothing on cfg_* reaches
  // an output combinationally.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      pend_q <= RstRatio;
      act_q  <= RstRatio;
      busy_q <= 1'b0;
      byp_q  <= RstBypass;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      busy_q <= busy_d;
      byp_q  <= byp_d;
    end
  end

  clkdiv_phase_gen #(
    .DIV_W (DIV_W)
  ) u_phase_gen (
    .clkin         (clkin),
    .rst           (rst),
    .act_ratio_i   (act_q),
    .bypass_i      (byp_q),
    .bypass_next_i (byp_d),
    .boundary_o    (boundary),
    .clkdiv_o      (clkdiv)
  );

  assign cfg_busy  = busy_q;
  assign act_ratio = act_q;
  assign bypass    = byp_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider. Pulse widths are measured in half clkin cycles and scoreboarded
// against the ratio each scenario programs (a ratio N gives high = N halves and period = 2N).
module tb_prog_clk_divider;

  localparam int unsigned DivW = 8;

  logic            clkin = 1'b0;
  logic            rst;
  logic            cfg_wr;
  logic [DivW-1:0] cfg_ratio;
  logic            cfg_busy;
  logic [DivW-1:0] act_ratio;
  logic            clkdiv;
  logic            bypass;

  typedef struct packed {
    int unsigned high;
    int unsigned period;
  } pulse_t;

  pulse_t      exp_q[$];
  pulse_t      meas_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned hc = 0;
  int unsigned last_rise = 0;
  int unsigned last_fall = 0;
  int unsigned rise_cnt = 0;
  int unsigned min_hi = 32'hFFFF_FFFF;
  int unsigned min_lo = 32'hFFFF_FFFF;
  int unsigned min_clr = 0;
  int unsigned min_clr_seen = 0;
  bit          have_rise = 1'b0;
  logic        prev_div = 1'b0;

  always #5 clkin = ~clkin;

  prog_clk_divider #(
    .DIV_W     (DivW),
    .RST_RATIO (2)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_ratio (cfg_ratio),
    .cfg_busy  (cfg_busy),
    .act_ratio (act_ratio),
    .clkdiv    (clkdiv),
    .bypass    (bypass)
  );

  // Pulse monitor: samples 1 time unit after every clkin edge and records each complete period.
  always @(posedge clkin or negedge clkin) begin
    #1;
    hc++;
    if (min_clr != min_clr_seen) begin
      min_clr_seen = min_clr;
      min_hi = 32'hFFFF_FFFF;
      min_lo = 32'hFFFF_FFFF;
    end
    if (clkdiv === 1'b1 && prev_div !== 1'b1) begin
      if (have_rise) meas_q.push_back('{high: last_fall - last_rise, period: hc - last_rise});
      if (hc - last_fall < min_lo) min_lo = hc - last_fall;
      last_rise = hc;
      have_rise = 1'b1;
      rise_cnt++;
    end else if (clkdiv !== 1'b1 && prev_div === 1'b1) begin
      last_fall = hc;
      if (hc - last_rise < min_hi) min_hi = hc - last_rise;
    end
    prev_div = clkdiv;
  end

  task automatic write_ratio(input logic [DivW-1:0] n);
    @(negedge clkin);
    cfg_wr    = 1'b1;
    cfg_ratio = n;
    @(negedge clkin);
    cfg_wr    = 1'b0;
  endtask

  task automatic expect_pulses(input int unsigned n, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back('{high: n, period: 2 * n});
  endtask

  task automatic wait_idle(input string tag);
    for (int g = 0; g < 200 && cfg_busy !== 1'b0; g++) @(negedge clkin);
    checks++;
    if (cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: cfg_busy=%b required 0", tag, cfg_busy);
    end
  endtask

  task automatic wait_rise(input string tag);
    int unsigned r0;
    r0 = rise_cnt;
    for (int g = 0; g < 100 && rise_cnt == r0; g++) @(negedge clkin);
    checks++;
    if (rise_cnt == r0) begin
      errors++;
      $display("FAIL %s_rise_timeout: no clkdiv rising edge seen", tag);
    end
  endtask

  // Scoreboard drain: wait for the DUT to produce as many pulses as expected, then compare.
  task automatic sb_drain(input string tag);
    pulse_t e;
    pulse_t m;
    for (int g = 0; g < 400 && meas_q.size() < exp_q.size(); g++) @(negedge clkin);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (meas_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no pulse measured, required high=%0d period=%0d half-cycles",
                 tag, e.high, e.period);
      end else begin
        m = meas_q.pop_front();
        if (m !== e) begin
          errors++;
          $display("FAIL %s: high=%0d period=%0d, required high=%0d period=%0d half-cycles",
                   tag, m.high, m.period, e.high, e.period);
        end
      end
    end
  endtask

  // Write a ratio and wait until it takes effect.
  task automatic apply_ratio(input logic [DivW-1:0] n, input string tag);
    write_ratio(n);
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: cfg_busy=%b required 1", tag, cfg_busy);
    end
    wait_idle(tag);
    checks++;
    if (act_ratio !== n || bypass !== (n < 2)) begin
      errors++;
      $display("FAIL %s_applied: act_ratio=%0d bypass=%b, required %0d %b",
               tag, act_ratio, bypass, n, (n < 2));
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_wr    = 1'b0;
    cfg_ratio = '0;
    #2;
    checks++;
    if ({clkdiv, bypass, cfg_busy, act_ratio} !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL reset_state: clkdiv,bypass,busy,act=%b required %b",
               {clkdiv, bypass, cfg_busy, act_ratio}, {1'b0, 1'b0, 1'b0, 8'd2});
    end
    repeat (3) @(negedge clkin);
    rst = 1'b0;
    wait_rise("reset");
    meas_q.delete();
    expect_pulses(2, 3);
    sb_drain("reset_period2");
    // Mid-operation reset with a write pending: everything returns to reset values at once.
    write_ratio(8'd5);
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy: cfg_busy=%b required 1", cfg_busy);
    end
    @(posedge clkin);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({clkdiv, bypass, cfg_busy, act_ratio} !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL midreset_state: clkdiv,bypass,busy,act=%b required %b",
               {clkdiv, bypass, cfg_busy, act_ratio}, {1'b0, 1'b0, 1'b0, 8'd2});
    end
    @(negedge clkin);
    rst = 1'b0;
    repeat (10) @(negedge clkin);
    checks++;
    if (act_ratio !== 8'd2 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pend_lost: act=%0d busy=%b required 2 0", act_ratio, cfg_busy);
    end
  endtask

  task automatic test_even_ratio();
    apply_ratio(8'd4, "even4");
    meas_q.delete();
    expect_pulses(4, 3);
    sb_drain("even4_pulse");
  endtask

  task automatic test_odd_ratio();
    apply_ratio(8'd3, "odd3");
    meas_q.delete();
    expect_pulses(3, 2);
    sb_drain("odd3_pulse");
    min_clr++;
    apply_ratio(8'd7, "odd7");
    meas_q.delete();
    expect_pulses(7, 2);
    sb_drain("odd7_pulse");
    checks++;
    if (min_hi < 3 || min_lo < 3) begin
      errors++;
      $display("FAIL odd_changeover_glitch: min high=%0d low=%0d half-cycles, required >= 3",
               min_hi, min_lo);
    end
  endtask

  task automatic test_mid_update();
    apply_ratio(8'd6, "mid6");
    meas_q.delete();
    expect_pulses(6, 1);
    @(negedge clkin);
    write_ratio(8'd5);  // sampled while the count is 2
    checks++;
    if (cfg_busy !== 1'b1 || act_ratio !== 8'd6) begin
      errors++;
      $display("FAIL mid_pending: busy=%b act=%0d required 1 6", cfg_busy, act_ratio);
    end
    expect_pulses(5, 2);
    sb_drain("mid_6_then_5");
    // Two writes inside one period: only the last one is applied.
    wait_rise("mid_last");
    write_ratio(8'd9);
    write_ratio(8'd10);
    checks++;
    if (cfg_busy !== 1'b1 || act_ratio !== 8'd5) begin
      errors++;
      $display("FAIL mid_double_pending: busy=%b act=%0d required 1 5", cfg_busy, act_ratio);
    end
    wait_idle("mid_last");
    checks++;
    if (act_ratio !== 8'd10) begin
      errors++;
      $display("FAIL mid_last_wins: act=%0d required 10", act_ratio);
    end
    meas_q.delete();
    expect_pulses(10, 2);
    sb_drain("mid_10_pulse");
  endtask

  task automatic test_bypass();
    int unsigned r0;
    apply_ratio(8'd1, "byp1");
    r0 = rise_cnt;
    repeat (10) @(negedge clkin);
    checks++;
    if (clkdiv !== 1'b0 || rise_cnt != r0) begin
      errors++;
      $display("FAIL byp1_quiet: clkdiv=%b rises=%0d required 0 and 0", clkdiv, rise_cnt - r0);
    end
    apply_ratio(8'd0, "byp0");
    // Exit: applied on the posedge after the write, first rise one posedge later.
    write_ratio(8'd4);
    checks++;
    if (cfg_busy !== 1'b1 || bypass !== 1'b1) begin
      errors++;
      $display("FAIL bypexit_pending: busy=%b bypass=%b required 1 1", cfg_busy, bypass);
    end
    @(negedge clkin);
    checks++;
    if ({bypass, cfg_busy, act_ratio, clkdiv} !== {1'b0, 1'b0, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL bypexit_apply: bypass,busy,act,clkdiv=%b required %b",
               {bypass, cfg_busy, act_ratio, clkdiv}, {1'b0, 1'b0, 8'd4, 1'b0});
    end
    @(negedge clkin);
    checks++;
    if (clkdiv !== 1'b1) begin
      errors++;
      $display("FAIL bypexit_first_rise: clkdiv=%b required 1", clkdiv);
    end
    meas_q.delete();
    expect_pulses(4, 2);
    sb_drain("bypexit_pulse");
  endtask

  task automatic test_write_at_boundary();
    wait_rise("bnd");
    write_ratio(8'd6);  // sampled while the count is 1
    write_ratio(8'd8);  // sampled on the count==3 boundary edge
    checks++;
    if (act_ratio !== 8'd6 || cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL bnd_prior_applied: act=%0d busy=%b required 6 1", act_ratio, cfg_busy);
    end
    meas_q.delete();
    expect_pulses(6, 1);
    sb_drain("bnd_6_pulse");
    wait_idle("bnd");
    checks++;
    if (act_ratio !== 8'd8) begin
      errors++;
      $display("FAIL bnd_new_applied: act=%0d required 8", act_ratio);
    end
    meas_q.delete();
    expect_pulses(8, 2);
    sb_drain("bnd_8_pulse");
  endtask

  task automatic test_equal_ratio();
    wait_rise("equal");
    meas_q.delete();
    write_ratio(8'd8);
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL equal_busy: cfg_busy=%b required 1", cfg_busy);
    end
    expect_pulses(8, 2);
    sb_drain("equal_pulse");
    checks++;
    if (act_ratio !== 8'd8 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL equal_final: act=%0d busy=%b required 8 0", act_ratio, cfg_busy);
    end
  endtask

  initial begin
    test_reset();
    test_even_ratio();
    test_odd_ratio();
    test_mid_update();
    test_bypass();
    test_write_at_boundary();
    test_equal_ratio();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
